// File: rtl/muldiv_controller.sv
// muldiv_controller: HI/LO sequencing for MIPS-style multiply/divide.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage, latches the
// operands, drives an external fixed-latency multiplier and a handshake
// divider, and owns the architectural HI/LO registers.
//
// Ports
//   clock, reset          single clock, asynchronous active-high reset
//   req_valid/op/src1/src2  request from EX; req_ready = accepted this cycle
//   req_done              one-cycle pulse; HI/LO update at the closing edge
//   flush                 abandon any in-flight operation
//   mul_*                 multiplier operands / 64-bit result
//   div_*                 divider request, operands and response
//   hi_value, lo_value    architectural HI/LO
//   busy                  high whenever the controller is not idle
//
// Configuration
//   MULDIV_HILO_BYPASS_EN  when defined, hi_value/lo_value show the value
//                          being written during the req_done cycle.
module muldiv_controller #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        req_ready,
    output logic        req_done,
    input  logic        flush,
    output logic [31:0] mul_input1,
    output logic [31:0] mul_input2,
    output logic        mul_signed,
    input  logic [63:0] mul_result,
    output logic        div_request_valid,
    output logic        div_signed,
    output logic [31:0] div_input1,
    output logic [31:0] div_input2,
    input  logic        div_result_valid,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic [31:0] hi_value,
    output logic [31:0] lo_value,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [2:0] MUL_INIT = 3'(MUL_LATENCY - 1);

    state_t      state;
    logic [2:0]  wait_cnt;
    logic [31:0] hi_q, lo_q, op1_q, op2_q;
    logic [31:0] hi_nxt, lo_nxt;
    logic        sign_q, busy_q, dreq_q;

    logic legal, accept, is_mul, is_div, is_mt, div_zero, mul_fin, div_fin;

    assign req_ready = (state == IDLE) & ~flush & ~reset;
    assign legal     = (req_op <= 3'd5);
    assign accept    = req_valid & req_ready & legal;
    assign is_mul    = accept & (req_op[2:1] == 2'b00);
    assign is_div    = accept & (req_op[2:1] == 2'b01);
    assign is_mt     = accept & req_op[2];
    assign div_zero  = is_div & (req_src2 == 32'd0);

    // flush must win over a coincident completion
    assign mul_fin   = (state == MUL) & (wait_cnt == 3'd0) & ~flush;
    assign div_fin   = (state == DIV) & div_result_valid & ~flush;

    // MTHI/MTLO and divide-by-zero complete in the acceptance cycle itself
    assign req_done  = is_mt | div_zero | mul_fin | div_fin;

    always_comb begin
        hi_nxt = hi_q;
        lo_nxt = lo_q;
        if (is_mt && !req_op[0]) hi_nxt = req_src1;
        if (is_mt &&  req_op[0]) lo_nxt = req_src1;
        if (mul_fin) {hi_nxt, lo_nxt} = mul_result;
        if (div_fin) begin
            hi_nxt = div_remainder;
            lo_nxt = div_quotient;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            dreq_q   <= 1'b0;
        end else begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            if (accept) begin
                op1_q  <= req_src1;
                op2_q  <= req_src2;
                sign_q <= ~req_op[0];   // MULT/DIV have op[0] = 0
            end
            if (flush) begin
                state    <= IDLE;
                wait_cnt <= '0;
                busy_q   <= 1'b0;
                dreq_q   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (is_mul) begin
                            state    <= MUL;
                            wait_cnt <= MUL_INIT;
                            busy_q   <= 1'b1;
                        end else if (is_div && !div_zero) begin
                            state  <= DIV;
                            busy_q <= 1'b1;
                            dreq_q <= 1'b1;
                        end
                    end
                    MUL: begin
                        if (wait_cnt == 3'd0) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt - 3'd1;
                        end
                    end
                    DIV: begin
                        if (div_result_valid) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            dreq_q <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        dreq_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy              = busy_q;
    assign div_request_valid = dreq_q;
    assign mul_input1        = op1_q;
    assign mul_input2        = op2_q;
    assign mul_signed        = sign_q;
    assign div_input1        = op1_q;
    assign div_input2        = op2_q;
    assign div_signed        = sign_q;

`ifdef MULDIV_HILO_BYPASS_EN
    assign hi_value = hi_nxt;
    assign lo_value = lo_nxt;
`else
    assign hi_value = hi_q;
    assign lo_value = lo_q;
`endif

endmodule

// File: tb/tb_muldiv_controller.sv
module tb_muldiv_controller;
    localparam int ML = 2;

    logic        clock = 0, reset = 1;
    logic        req_valid = 0, flush = 0;
    logic [2:0]  req_op = 0;
    logic [31:0] req_src1 = 0, req_src2 = 0;
    logic        req_ready, req_done, mul_signed, div_request_valid, div_signed, busy;
    logic [31:0] mul_input1, mul_input2, div_input1, div_input2, hi_value, lo_value;
    logic [63:0] mul_result;
    logic        div_result_valid;
    logic [31:0] div_quotient, div_remainder;

    int checks = 0, errors = 0;
    logic [31:0] exp_hi = 0, exp_lo = 0;
    int div_delay = 1000;
    logic force_dv = 0;

    muldiv_controller #(.MUL_LATENCY(ML)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .req_ready(req_ready),
        .req_done(req_done), .flush(flush), .mul_input1(mul_input1),
        .mul_input2(mul_input2), .mul_signed(mul_signed), .mul_result(mul_result),
        .div_request_valid(div_request_valid), .div_signed(div_signed),
        .div_input1(div_input1), .div_input2(div_input2),
        .div_result_valid(div_result_valid), .div_quotient(div_quotient),
        .div_remainder(div_remainder), .hi_value(hi_value), .lo_value(lo_value),
        .busy(busy)
    );

    always #5 clock = ~clock;

    // Multiplier environment: product appears ML cycles after its inputs settle.
    logic [63:0] prod_now;
    logic [63:0] prod_q [0:7];
    always_comb begin
        prod_now = mul_signed ? ($signed({{32{mul_input1[31]}}, mul_input1}) *
                                 $signed({{32{mul_input2[31]}}, mul_input2}))
                              : ({32'b0, mul_input1} * {32'b0, mul_input2});
    end
    always_ff @(posedge clock) begin
        prod_q[0] <= prod_now;
        for (int i = 1; i < 8; i++) prod_q[i] <= prod_q[i-1];
    end
    assign mul_result = (ML == 1) ? prod_now : prod_q[ML-2];

    // Divider environment: answers in the div_delay-th requesting cycle.
    int div_cnt = 0;
    always_ff @(posedge clock) div_cnt <= div_request_valid ? div_cnt + 1 : 0;
    assign div_result_valid = (div_request_valid && div_cnt == div_delay - 1) || force_dv;
    always_comb begin
        div_quotient = 0;
        div_remainder = 0;
        if (div_input2 != 0) begin
            if (div_signed) begin
                div_quotient  = $signed(div_input1) / $signed(div_input2);
                div_remainder = $signed(div_input1) % $signed(div_input2);
            end else begin
                div_quotient  = div_input1 / div_input2;
                div_remainder = div_input1 % div_input2;
            end
        end
    end

    // Issue one request and follow it to completion, checking against the model.
    // Entered and left just after a rising edge with the controller idle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int dly);
        logic [31:0] nh, nl;
        longint sp;
        int sa, sb, exp_lat, lat;
        bit done, seen_dreq;
        nh = exp_hi; nl = exp_lo; exp_lat = 0;
        sa = a; sb = b;
        case (op)
            3'd0: begin sp = longint'(sa) * longint'(sb); {nh, nl} = sp; exp_lat = ML; end
            3'd1: begin {nh, nl} = {32'b0, a} * {32'b0, b}; exp_lat = ML; end
            3'd2: if (b != 0) begin nl = sa / sb; nh = sa % sb; exp_lat = dly; end
            3'd3: if (b != 0) begin nl = a / b; nh = a % b; exp_lat = dly; end
            3'd4: nh = a;
            default: nl = a;
        endcase
        div_delay = dly;
        req_valid = 1; req_op = op; req_src1 = a; req_src2 = b;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL accept_ready op=%0d got %b want 1", op, req_ready); end
        done = req_done;
        seen_dreq = div_request_valid;
        lat = 0;
        while (!done) begin
            @(posedge clock); #1;
            // garbage while busy: must be held off and must not disturb latched operands
            req_op = 3'($urandom_range(0, 5)); req_src1 = $urandom; req_src2 = $urandom;
            lat++;
            @(negedge clock);
            if (div_request_valid) seen_dreq = 1;
            checks++;
            if (req_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL busy_holdoff ready=%b busy=%b want 0/1", req_ready, busy);
            end
            if (lat == 1) begin
                checks++;
                if (mul_input1 !== a || div_input2 !== b || mul_signed !== ~op[0] || div_signed !== ~op[0]) begin
                    errors++;
                    $display("FAIL operand_latch in1=%h in2=%h sg=%b want %h %h %b", mul_input1, div_input2, mul_signed, a, b, ~op[0]);
                end
            end
            done = req_done;
            if (lat > 300) begin errors++; $display("FAIL timeout op=%0d no req_done", op); break; end
        end
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL latency op=%0d got %0d want %0d", op, lat, exp_lat); end
        checks++;
`ifdef MULDIV_HILO_BYPASS_EN
        if (hi_value !== nh || lo_value !== nl) begin
            errors++; $display("FAIL done_cycle_view hi=%h lo=%h want %h %h", hi_value, lo_value, nh, nl);
        end
`else
        if (hi_value !== exp_hi || lo_value !== exp_lo) begin
            errors++; $display("FAIL done_cycle_view hi=%h lo=%h want %h %h", hi_value, lo_value, exp_hi, exp_lo);
        end
`endif
        checks++;
        if (seen_dreq !== (op[2:1] == 2'b01 && b != 0)) begin
            errors++; $display("FAIL div_request op=%0d b=%h got %b", op, b, seen_dreq);
        end
        @(posedge clock); #1;
        req_valid = 0;
        exp_hi = nh; exp_lo = nl;
        checks++;
        if (hi_value !== exp_hi || lo_value !== exp_lo || busy !== 1'b0) begin
            errors++; $display("FAIL hilo op=%0d a=%h b=%h got %h_%h busy=%b want %h_%h", op, a, b, hi_value, lo_value, busy, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if (req_ready !== 0 || req_done !== 0 || busy !== 0 || div_request_valid !== 0 ||
            hi_value !== 0 || lo_value !== 0 || mul_input1 !== 0 || div_input2 !== 0) begin
            errors++; $display("FAIL reset_state rdy=%b done=%b busy=%b dreq=%b hi=%h lo=%h", req_ready, req_done, busy, div_request_valid, hi_value, lo_value);
        end
        @(posedge clock); #1;
        reset = 0;
    endtask

    task automatic test_directed();
        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1);      // MULT -> HI FFFFFFFF, LO FFFFFFFA
        checks++;
        if (hi_value !== 32'hFFFFFFFF || lo_value !== 32'hFFFFFFFA) begin
            errors++; $display("FAIL mult_directed got %h_%h want ffffffff_fffffffa", hi_value, lo_value);
        end
        run_op(3'd3, 32'd100, 32'd7, 33);          // DIVU, 33 busy cycles
        checks++;
        if (hi_value !== 32'd2 || lo_value !== 32'd14) begin
            errors++; $display("FAIL divu_directed got %h_%h want 2_14", hi_value, lo_value);
        end
    endtask

    task automatic test_div_zero();
        run_op(3'd4, 32'h1234, 32'd0, 1);
        run_op(3'd2, 32'd55, 32'd0, 5);
        checks++;
        if (hi_value !== 32'h1234) begin errors++; $display("FAIL div_zero_hi got %h want 1234", hi_value); end
    endtask

    task automatic test_flush_div();
        logic [31:0] h0, l0;
        h0 = exp_hi; l0 = exp_lo;
        div_delay = 1000;
        req_valid = 1; req_op = 3'd2; req_src1 = 32'd50; req_src2 = 32'd3;
        @(posedge clock); #1;
        req_valid = 0;
        repeat (3) @(posedge clock);
        #1; flush = 1; force_dv = 1;
        @(negedge clock);
        checks++;
        if (req_done !== 0) begin errors++; $display("FAIL flush_done got %b want 0", req_done); end
        @(posedge clock); #1;
        flush = 0; force_dv = 0;
        checks++;
        if (busy !== 0 || div_request_valid !== 0 || hi_value !== h0 || lo_value !== l0) begin
            errors++; $display("FAIL flush_after busy=%b dreq=%b hi=%h lo=%h want 0 0 %h %h", busy, div_request_valid, hi_value, lo_value, h0, l0);
        end
        run_op(3'd5, 32'd5, 32'd0, 1);
        checks++;
        if (lo_value !== 32'd5) begin errors++; $display("FAIL flush_mtlo got %h want 5", lo_value); end
    endtask

    task automatic test_bypass();
        run_op(3'd4, 32'h11, 32'd0, 1);
        run_op(3'd4, 32'hAB, 32'd0, 1);
    endtask

    task automatic test_ignored();
        logic [31:0] h0, l0;
        h0 = exp_hi; l0 = exp_lo;
        force_dv = 1;                               // stray divider response
        req_valid = 1; req_op = 3'd6; req_src1 = 32'hDEAD; req_src2 = 32'd1;  // illegal op
        @(negedge clock);
        checks++;
        if (req_done !== 0) begin errors++; $display("FAIL ignored_done got %b want 0", req_done); end
        @(posedge clock); #1;
        req_valid = 0; force_dv = 0;
        checks++;
        if (busy !== 0 || hi_value !== h0 || lo_value !== l0) begin
            errors++; $display("FAIL ignored_state busy=%b hi=%h lo=%h want 0 %h %h", busy, hi_value, lo_value, h0, l0);
        end
    endtask

    task automatic test_reset_mid_mul();
        run_op(3'd4, 32'hDEAD, 32'd0, 1);
        req_valid = 1; req_op = 3'd1; req_src1 = 32'd9; req_src2 = 32'd9;
        @(posedge clock); #1;
        req_valid = 0;
        #2 reset = 1;
        #1;
        checks++;
        if (busy !== 0 || hi_value !== 0 || lo_value !== 0 || req_done !== 0) begin
            errors++; $display("FAIL reset_mid_mul busy=%b hi=%h lo=%h done=%b want 0 0 0 0", busy, hi_value, lo_value, req_done);
        end
        exp_hi = 0; exp_lo = 0;
        @(posedge clock); #1;
        reset = 0;
        run_op(3'd5, 32'h77, 32'd0, 1);             // accepted in first cycle after reset
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [31:0] a, b;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 5));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 1) == 1) b = b & 32'hFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            run_op(op, a, b, int'($urandom_range(1, 12)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_flush_div();
        test_bypass();
        test_ignored();
        test_reset_mid_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
